// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - resolved-branch FIFO with ROB write-back and fetch redirect
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int DEPTH          = 4,
  parameter int INST_TAG_WIDTH = 6,
  parameter int COMMON_WIDTH   = 32,
  parameter logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INST_TAG_WIDTH-1:0] in_tag,
  input  logic                      in_taken,
  input  logic [COMMON_WIDTH-1:0]   in_target_pc,
  input  logic                      flush,
  output logic                      wb_valid,
  output logic [INST_TAG_WIDTH-1:0] wb_tag,
  output logic                      wb_taken,
  input  logic                      wb_ready,
  output logic                      redirect_valid,
  output logic [COMMON_WIDTH-1:0]   redirect_pc,
  input  logic                      redirect_ack,
  output logic                      overflow
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]               stat_resolved,
  output logic [31:0]               stat_redirects
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REDIRECT} state_t;

  typedef struct packed {
    logic [INST_TAG_WIDTH-1:0] tag;
    logic                      taken;
    logic [COMMON_WIDTH-1:0]   pc;
  } entry_t;

  state_t      state, state_nxt;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [IW:0] wr_ptr, rd_ptr, count;
  logic        full, in_valid, accepting, push, pop, drop, ack;

  assign head      = mem[rd_ptr[IW-1:0]];
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign in_valid  = (in_tag != TAG_INVALID);
  assign accepting = (state == S_IDLE) || (state == S_WB);
  assign pop       = wb_valid && wb_ready;
  // A full queue still takes a new result when the head leaves in the same cycle.
  assign push      = in_valid && accepting && (!full || pop) && !flush;
  assign drop      = in_valid && accepting && full && !pop && !flush;
  assign ack       = (state == S_REDIRECT) && redirect_ack;

  assign wb_valid       = (state == S_WB);
  assign wb_tag         = wb_valid ? head.tag : TAG_INVALID;
  assign wb_taken       = wb_valid && head.taken;
  assign redirect_valid = (state == S_REDIRECT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (push) state_nxt = S_WB;
      S_WB: begin
        if (pop) begin
          if (head.taken)              state_nxt = S_REDIRECT;
          else if (count == PTR_ONE && !push) state_nxt = S_IDLE;
        end
      end
      S_REDIRECT: if (redirect_ack) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      redirect_pc <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      // The whole queue belongs to the squashed path once a redirect is taken.
      if (flush || ack) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + PTR_ONE;
        else if (pop && !push) count <= count - PTR_ONE;
      end
      if (pop && head.taken) redirect_pc <= head.pc;
      if (drop)              overflow    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= '{tag: in_tag, taken: in_taken, pc: in_target_pc};
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved  <= '0;
      stat_redirects <= '0;
    end else begin
      if (pop && stat_resolved != '1)  stat_resolved  <= stat_resolved + 32'd1;
      if (ack && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule
